scratch_ram_slave: RTL and testbench
====================================

# scratch_ram_slave

On-chip block-RAM slave on the shared Avalon-style CPU bus, driven directly by the CPU bus master and decoded for the low DRAM window (byte addresses 0x0000_0000-0x0000_7FFF). It serves single-word and 16-beat line bursts for reads and writes and returns one write response per write burst. Because slave outputs are OR-combined on the bus, every output is zero whenever the block is not actively responding.

## Interface
- BASE_WADDR, 30'h0: word-address base of the window.
- ADDR_BITS, 13: log2 of depth in 32-bit words. 8192 words = 32 KiB.
- MAX_BURST, 16: largest legal burstcount.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- bus_address  in  30  word address.
- bus_read  in  1  read command.
- bus_write  in  1  write beat strobe.
- bus_burstcount  in  5  beats. Sampled only on the accepted command or first write beat.
- bus_writedata  in  32  write data.
- bus_byteenable  in  4  per-beat byte lanes.
- s_waitrequest  out  1  command/beat stall.
- s_readdata  out  32  read data. Zero unless s_readdatavalid.
- s_readdatavalid  out  1  one pulse per read beat.
- s_response  out  2  always 2'b00 (OKAY).
- s_writeresponsevalid  out  1  one pulse per write burst.

## Operation
- Select: sel = (bus_address[29:ADDR_BITS] == BASE_WADDR[29:ADDR_BITS]) & (bus_read | bus_write).
  - Unselected cycles are ignored.
  - All outputs are 0 on unselected cycles, except s_readdatavalid and s_writeresponsevalid while a burst already accepted is still completing.
- Burst length: len = bus_burstcount, with 0 treated as 1 and values above MAX_BURST clamped to MAX_BURST.
- Beat address: a beat's RAM index is (start + k) mod 2^ADDR_BITS, for k = 0..len-1. Wrap is silent.
- States:
  - IDLE
    - Selected read with s_waitrequest=0: latch start = bus_address[ADDR_BITS-1:0] and beats = len, go to RD.
    - Selected write with s_waitrequest=0: write beat 0 with its byteenable. If len=1 go to WRESP, else latch start and beats = len-1 and go to WR.
  - RD
    - Emit one beat per cycle: s_readdatavalid=1 with RAM[start+k].
    - After the last beat, return to IDLE.
  - WR
    - Each cycle with bus_write=1 writes the next word and decrements beats.
    - bus_address and bus_burstcount are ignored in WR; the master holds address constant and decrements burstcount.
    - bus_write=0 cycles are idle, not errors.
    - When beats reaches 0, go to WRESP.
  - WRESP: pulse s_writeresponsevalid for one cycle, then go to IDLE.
- s_waitrequest = sel & (state is RD, or WRESP, or IDLE with a response still in flight).
  - s_waitrequest is 0 in WR, so data beats are never stalled.
- Byte lanes: byteenable bit i controls byte lane [8i+7:8i]. Reads ignore byteenable.
- Reset: state returns to IDLE, any in-flight burst is abandoned with no further valid pulses, and RAM contents are preserved.

## Timing
- Reset values: s_waitrequest=0, s_readdata=0, s_readdatavalid=0, s_response=0, s_writeresponsevalid=0.
- Read latency: command accepted in cycle N gives beat k valid in cycle N+1+k. Beats are back-to-back with no gaps.
- Write: last beat accepted in cycle M gives s_writeresponsevalid in cycle M+1. A single-beat write gives the response in the cycle after acceptance.
- A new command is accepted no earlier than the cycle after the final readdatavalid or writeresponsevalid pulse. Earlier attempts see s_waitrequest=1 and are held by the master.
- Read-after-write to the same word returns the new data, because the write completes before the response.
- A write beat and read data never share a cycle, since bursts are serialized.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, with bus_read=1 at 0x10 the whole time. All outputs stay 0 and no beats are emitted.
- Single write/read:
  - Write 0xDEADBEEF to word 0x004, byteenable 4'hF, burstcount 1. s_writeresponsevalid appears 1 cycle later.
  - Read 0x004, burstcount 1. readdatavalid 1 cycle after acceptance, with readdata 0xDEADBEEF.
- Byte enable: write 0x11223344 with byteenable 4'b0101 over 0xDEADBEEF, then read back. Result is 0xDE22BE44.
- Line burst:
  - 16-beat write starting at 0x1FF8, with data = beat index, including 3 idle cycles mid-burst. Exactly one writeresponsevalid.
  - 16-beat read from 0x1FF8 returns 0..15 on 16 consecutive cycles.
  - Beat 8 lands at RAM index 0x0000 (wrap).
- Backpressure and isolation:
  - A read at 0x0020 issued while a 16-beat read is streaming sees s_waitrequest=1 until the last beat, then is accepted.
  - A read to 0x0000_2000 (outside the window, word address 30'h2000) produces no outputs at all.
- Reset mid-burst: assert rst_n=0 at beat 5 of a 16-beat read. No further readdatavalid pulses, and a subsequent read of the same address returns the correct data.

Source files
------------

// File: rtl/scratch_ram_slave_if.sv
// Avalon-style CPU bus bundle between the bus master and the scratch RAM slave.
// Slave outputs are OR-combined on the shared bus.
interface scratch_ram_slave_if;
  logic [29:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [4:0]  bus_burstcount;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [1:0]  s_response;
  logic        s_writeresponsevalid;

  modport master (
    output bus_address, bus_read, bus_write, bus_burstcount, bus_writedata, bus_byteenable,
    input  s_waitrequest, s_readdata, s_readdatavalid, s_response, s_writeresponsevalid
  );

  modport slave (
    input  bus_address, bus_read, bus_write, bus_burstcount, bus_writedata, bus_byteenable,
    output s_waitrequest, s_readdata, s_readdatavalid, s_response, s_writeresponsevalid
  );
endinterface

// File: rtl/scratch_ram_slave.sv
// Block-RAM slave for the low DRAM window: single-word and line bursts, one write
// response per write burst, all outputs zero while not responding.
module scratch_ram_slave #(
  parameter logic [29:0] BASE_WADDR = 30'h0,
  parameter int unsigned ADDR_BITS  = 13,
  parameter int unsigned MAX_BURST  = 16
) (
  input logic                clk,
  input logic                rst_n,
  scratch_ram_slave_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WRESP
  } state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0]  ptr;
  logic [4:0]            beats;
  logic [31:0]           rdata;
  logic                  rvalid;
  logic                  bvalid;

  logic                  sel;
  logic [ADDR_BITS-1:0]  cmd_idx;
  logic [4:0]            len;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  wr_beat;
  logic                  we;
  logic [ADDR_BITS-1:0]  widx;

  always_comb begin
    sel     = (bus.bus_address[29:ADDR_BITS] == BASE_WADDR[29:ADDR_BITS]) &
              (bus.bus_read | bus.bus_write);
    cmd_idx = bus.bus_address[ADDR_BITS-1:0];
    if (bus.bus_burstcount == '0)
      len = 5'd1;
    else if (bus.bus_burstcount > 5'(MAX_BURST))
      len = 5'(MAX_BURST);
    else
      len = bus.bus_burstcount;
    // Read wins when a master raises both strobes in the same cycle.
    acc_rd  = rst_n & sel & (state == ST_IDLE) & bus.bus_read;
    acc_wr  = rst_n & sel & (state == ST_IDLE) & ~bus.bus_read & bus.bus_write;
    wr_beat = rst_n & (state == ST_WR) & bus.bus_write;
    we      = acc_wr | wr_beat;
    widx    = acc_wr ? cmd_idx : ptr;
  end

  // RAM has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.bus_byteenable[i])
          mem[widx][8*i +: 8] <= bus.bus_writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      beats  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      bvalid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rvalid <= 1'b0;
          bvalid <= 1'b0;
          rdata  <= '0;
          if (acc_rd) begin
            // Beat 0 is fetched here; beats counts the ones still to come.
            rdata  <= mem[cmd_idx];
            rvalid <= 1'b1;
            ptr    <= cmd_idx + 1'b1;
            beats  <= len - 5'd1;
            state  <= ST_RD;
          end else if (acc_wr) begin
            if (len == 5'd1) begin
              bvalid <= 1'b1;
              state  <= ST_WRESP;
            end else begin
              ptr   <= cmd_idx + 1'b1;
              beats <= len - 5'd1;
              state <= ST_WR;
            end
          end
        end
        ST_RD: begin
          if (beats == '0) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            state  <= ST_IDLE;
          end else begin
            rdata <= mem[ptr];
            ptr   <= ptr + 1'b1;
            beats <= beats - 5'd1;
          end
        end
        ST_WR: begin
          if (bus.bus_write) begin
            ptr   <= ptr + 1'b1;
            beats <= beats - 5'd1;
            if (beats == 5'd1) begin
              bvalid <= 1'b1;
              state  <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          bvalid <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_waitrequest        = sel & ((state == ST_RD) | (state == ST_WRESP));
  assign bus.s_readdata           = rdata;
  assign bus.s_readdatavalid      = rvalid;
  assign bus.s_response           = '0;
  assign bus.s_writeresponsevalid = bvalid;
endmodule

// File: tb/tb_scratch_ram_slave.sv
// Directed bench for scratch_ram_slave: reset, single/byte-lane access, wrapping
// line bursts, backpressure, window isolation, burst-length clamping and mid-burst reset.
module tb_scratch_ram_slave;
  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  scratch_ram_slave_if bus ();

  scratch_ram_slave #(
    .BASE_WADDR (30'h0),
    .ADDR_BITS  (13),
    .MAX_BURST  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.bus_read       = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_address    = '0;
    bus.bus_burstcount = '0;
    bus.bus_writedata  = '0;
    bus.bus_byteenable = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wait"},  32'(bus.s_waitrequest), 32'd0);
    check({tag, "_rv"},    32'(bus.s_readdatavalid), 32'd0);
    check({tag, "_rdata"}, bus.s_readdata, 32'd0);
    check({tag, "_resp"},  32'(bus.s_response), 32'd0);
    check({tag, "_bv"},    32'(bus.s_writeresponsevalid), 32'd0);
  endtask

  // n beats of data first+k; 3 idle cycles are inserted before beat gap_at.
  task automatic write_seq(input logic [29:0] addr, input int unsigned n,
                           input logic [31:0] first, input logic [3:0] be,
                           input int unsigned gap_at);
    for (int unsigned k = 0; k < n; k++) begin
      if (k == gap_at) begin
        bus.bus_write = 1'b0;
        for (int unsigned g = 0; g < 3; g++) begin
          #1;
          check("wr_gap_bv", 32'(bus.s_writeresponsevalid), 32'd0);
          tick();
        end
      end
      bus.bus_write      = 1'b1;
      bus.bus_address    = addr;
      bus.bus_burstcount = 5'(n - k);
      bus.bus_writedata  = first + k;
      bus.bus_byteenable = be;
      #1;
      check("wr_wait", 32'(bus.s_waitrequest), 32'd0);
      check("wr_bv_early", 32'(bus.s_writeresponsevalid), 32'd0);
      tick();
    end
    idle();
    check("wr_bv", 32'(bus.s_writeresponsevalid), 32'd1);
    check("wr_rv", 32'(bus.s_readdatavalid), 32'd0);
    tick();
    check("wr_bv_end", 32'(bus.s_writeresponsevalid), 32'd0);
  endtask

  // Drives burstcount bc, expects n beats of first+k then silence.
  task automatic read_seq(input logic [29:0] addr, input logic [4:0] bc,
                          input int unsigned n, input logic [31:0] first);
    bus.bus_read       = 1'b1;
    bus.bus_address    = addr;
    bus.bus_burstcount = bc;
    #1;
    check("rd_wait", 32'(bus.s_waitrequest), 32'd0);
    tick();
    idle();
    for (int unsigned k = 0; k < n; k++) begin
      check("rd_rv", 32'(bus.s_readdatavalid), 32'd1);
      check("rd_data", bus.s_readdata, first + k);
      tick();
    end
    check("rd_end_rv", 32'(bus.s_readdatavalid), 32'd0);
    check("rd_end_data", bus.s_readdata, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n              = 1'b0;
    bus.bus_read       = 1'b1;
    bus.bus_address    = 30'h10;
    bus.bus_burstcount = 5'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_quiet("rst");
    end
    rst_n = 1'b1;
    idle();
    tick();
    check_quiet("post_rst");

    // Single word and byte lanes
    write_seq(30'h004, 1, 32'hDEADBEEF, 4'hF, 99);
    read_seq(30'h004, 5'd1, 1, 32'hDEADBEEF);
    write_seq(30'h004, 1, 32'h11223344, 4'b0101, 99);
    read_seq(30'h004, 5'd1, 1, 32'hDE22BE44);
    write_seq(30'h020, 1, 32'hCAFEF00D, 4'hF, 99);

    // Line burst wrapping past the top of the RAM
    write_seq(30'h1FF8, 16, 32'd0, 4'hF, 6);
    read_seq(30'h1FF8, 5'd16, 16, 32'd0);
    read_seq(30'h0000, 5'd1, 1, 32'd8);
    read_seq(30'h1FFF, 5'd1, 1, 32'd7);
    read_seq(30'h0004, 5'd1, 1, 32'd12);

    // Burstcount 0 means one beat, above 16 clamps to 16
    read_seq(30'h1FF8, 5'd0, 1, 32'd0);
    read_seq(30'h1FF8, 5'd20, 16, 32'd0);

    // Backpressure: second read held until the stream's last beat has gone
    bus.bus_read       = 1'b1;
    bus.bus_address    = 30'h1FF8;
    bus.bus_burstcount = 5'd16;
    #1;
    check("bp_first_wait", 32'(bus.s_waitrequest), 32'd0);
    tick();
    bus.bus_address    = 30'h020;
    bus.bus_burstcount = 5'd1;
    for (int unsigned k = 0; k < 16; k++) begin
      #1;
      check("bp_wait", 32'(bus.s_waitrequest), 32'd1);
      check("bp_rv", 32'(bus.s_readdatavalid), 32'd1);
      check("bp_data", bus.s_readdata, k);
      tick();
    end
    #1;
    check("bp_accept_wait", 32'(bus.s_waitrequest), 32'd0);
    check("bp_gap_rv", 32'(bus.s_readdatavalid), 32'd0);
    tick();
    idle();
    check("bp_rv2", 32'(bus.s_readdatavalid), 32'd1);
    check("bp_data2", bus.s_readdata, 32'hCAFEF00D);
    tick();
    check("bp_end_rv", 32'(bus.s_readdatavalid), 32'd0);

    // Outside the window: no response, and no aliasing into index 4
    bus.bus_read       = 1'b1;
    bus.bus_address    = 30'h2000;
    bus.bus_burstcount = 5'd4;
    #1;
    check_quiet("oow_rd_now");
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_quiet("oow_rd");
    end
    idle();
    bus.bus_write      = 1'b1;
    bus.bus_address    = 30'h2004;
    bus.bus_burstcount = 5'd1;
    bus.bus_writedata  = 32'h00000BAD;
    bus.bus_byteenable = 4'hF;
    #1;
    check_quiet("oow_wr_now");
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_quiet("oow_wr");
    end
    idle();
    tick();
    read_seq(30'h0004, 5'd1, 1, 32'd12);

    // Reset during beat 5 of a line read
    bus.bus_read       = 1'b1;
    bus.bus_address    = 30'h1FF8;
    bus.bus_burstcount = 5'd16;
    tick();
    idle();
    for (int unsigned k = 0; k < 5; k++) begin
      check("mr_data", bus.s_readdata, k);
      tick();
    end
    rst_n = 1'b0;
    tick();
    check_quiet("mr_in_rst");
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_quiet("mr_after");
    end
    read_seq(30'h1FF8, 5'd16, 16, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
